soc_decerr_responder: RTL
=========================

Name: soc_decerr_responder

Overview:
AXI4 default slave on the SoC crossbar that is the responding end for every address matching no rule of the SoC address map.
- Accepts any AW/W/AR burst.
- Drains write data and returns DECERR on B and R with correct ID and burst length, so the initiator never hangs.
- Captures the first offending address, counts errors and raises an interrupt for the PLIC.

Parameters:
IdWidth, 7, AXI ID width on crossbar master ports (5 + clog2 of 4 slave ports)
AddrWidth, 64, AXI address width
DataWidth, 64, AXI data width
ErrData, 64'hBADC_AB1E_BADC_AB1E, read-data pattern returned on every R beat
CntWidth, 16, width of saturating error counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
aw_id_i  in  IdWidth  write address ID
aw_addr_i  in  AddrWidth  write address
aw_valid_i  in  1  AW valid
aw_ready_o  out  1  AW ready
w_last_i  in  1  W last beat
w_valid_i  in  1  W valid
w_ready_o  out  1  W ready
b_id_o  out  IdWidth  B ID
b_resp_o  out  2  B response
b_valid_o  out  1  B valid
b_ready_i  in  1  B ready
ar_id_i  in  IdWidth  read address ID
ar_addr_i  in  AddrWidth  read address
ar_len_i  in  8  burst length minus one
ar_valid_i  in  1  AR valid
ar_ready_o  out  1  AR ready
r_id_o  out  IdWidth  R ID
r_data_o  out  DataWidth  R data
r_resp_o  out  2  R response
r_last_o  out  1  R last
r_valid_o  out  1  R valid
r_ready_i  in  1  R ready
err_clr_i  in  1  clear capture, counter and irq
err_addr_o  out  AddrWidth  first captured offending address
err_is_write_o  out  1  1 = captured error was a write
err_valid_o  out  1  capture register holds a value
err_cnt_o  out  CntWidth  saturating error count
irq_o  out  1  level interrupt, equals err_valid_o

Behaviour:
- Interface: one clock clk_i; reset rst_ni is synchronous, active-low.
- Reset values:
  - Both FSMs return to IDLE.
  - All valid and ready outputs are 0 except aw_ready_o = 1 and ar_ready_o = 1 (IDLE).
  - b_id_o, r_id_o, err_addr_o, err_cnt_o are 0; err_valid_o, irq_o, r_last_o are 0.
  - b_resp_o and r_resp_o are constantly 2'b11.
  - r_data_o is constantly ErrData.
- Reset mid-burst abandons the burst and drops all valids on the next edge.
- Write FSM (W_IDLE, W_DRAIN, W_RESP):
  - W_IDLE: aw_ready_o = 1. On AW handshake, latch aw_id_i and go to W_DRAIN.
  - W_DRAIN: w_ready_o = 1. Each W handshake is discarded. A handshake with w_last_i = 1 goes to W_RESP.
  - W_RESP: b_valid_o = 1 with the latched ID. Hold until b_ready_i; on handshake go to W_IDLE.
  - Latency: AW handshake at cycle n, w_ready_o high at n+1. w_last handshake at m, b_valid_o high at m+1.
  - W beats presented before AW are not accepted (w_ready_o = 0 outside W_DRAIN).
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: ar_ready_o = 1. On AR handshake, latch ID and len, clear the beat counter (8 bit), go to R_DATA.
  - R_DATA: r_valid_o = 1. r_last_o = 1 when beat counter == latched len. The counter increments on each R handshake. The last handshake goes to R_IDLE.
  - Output is stable while r_ready_i = 0.
  - Latency: first beat at n+1 after AR handshake. Throughput is 1 beat per cycle. len = 255 gives 256 beats with no wrap before last.
- The two FSMs are fully independent. Simultaneous AW and AR are both accepted in the same cycle.
- Error capture (on AW or AR handshake):
  - If err_valid_o = 0, latch the address and direction and set err_valid_o.
  - If AW and AR handshake in the same cycle, AW is captured and the counter increments by 2.
  - The counter saturates at all-ones.
  - err_clr_i clears capture and counter. If a handshake occurs in the same cycle as err_clr_i, that new error is captured and the counter becomes its count (1 or 2), so no event is lost.
- One outstanding transaction per direction; there is no interleaving.

Decomposition:
- The shared SoC package gains:
  - constant AxiRespDecErr = 2'b11
  - constant DecErrData
  - IdWidthSlave reused for IdWidth
  - a new PLIC source index constant for irq_o
- One sub-module is natural: soc_decerr_capture, which holds the capture register, the saturating counter and clear priority. The two channel FSMs stay in the top module.

Test Plan:
- Single write: AW id=7'h15 addr=64'h5000_0000, 1 W beat with last, b_ready=1 -> w_ready at n+1, B id=7'h15 resp=2'b11, err_addr=64'h5000_0000, err_is_write=1, irq=1, cnt=1.
- Read burst: AR id=3 len=3 addr=64'h6000_0000, r_ready=1 -> 4 beats of ErrData resp=2'b11, r_last only on 4th, id=3 on all beats.
- Backpressure: read len=1 with r_ready toggling 0/1 each cycle; B with b_ready=0 for 5 cycles -> outputs held stable, exactly 2 R beats and 1 B delivered.
- Simultaneous AW (addr A) and AR (addr B) in the same cycle -> both accepted, capture = A with is_write=1, cnt=2; a later AR does not overwrite the capture.
- err_clr_i in the same cycle as an AR handshake at 64'h7000_0000 -> err_valid stays 1, addr=64'h7000_0000, cnt=1. Saturation: drive 70000 errors with CntWidth=16 -> cnt=16'hFFFF.
- Reset mid-read (rst_ni=0 during beat 2 of len=7) -> next cycle r_valid=0, ar_ready=1, cnt=0; a following read completes normally.

Source files
------------

// File: rtl/soc_decerr_responder_pkg.sv
// Shared constants and state types for the SoC decode-error responder.
package soc_decerr_responder_pkg;

  // AXI DECERR response code.
  localparam logic [1:0] AxiRespDecErr = 2'b11;

  // Recognisable read-data pattern returned on every R beat.
  localparam logic [63:0] DecErrData = 64'hBADC_AB1E_BADC_AB1E;

  // ID width on crossbar master ports (5 + clog2 of 4 slave ports).
  localparam int unsigned IdWidthSlave = 7;

  // PLIC source index wired to irq_o.
  localparam int unsigned PlicSrcDecErr = 12;

  typedef enum logic [1:0] {
    WIdle,
    WDrain,
    WResp
  } w_state_e;

  typedef enum logic [0:0] {
    RIdle,
    RData
  } r_state_e;

endpackage

// File: rtl/soc_decerr_capture.sv
// First-error address capture plus saturating error counter with clear.
module soc_decerr_capture
  import soc_decerr_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 aw_hs_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 ar_hs_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_is_write_o,
  output logic                 err_valid_o,
  output logic [CntWidth-1:0]  err_cnt_o
);

  localparam int unsigned SumWidth = CntWidth + 1;

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 is_write_q, is_write_d;
  logic                 valid_q, valid_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic                 base_valid;
  logic [CntWidth-1:0]  base_cnt;
  logic [1:0]           inc;
  logic [SumWidth-1:0]  sum;

  // Clear acts first so a same-cycle handshake lands on an empty capture.
  always_comb begin
    base_valid = clr_i ? 1'b0 : valid_q;
    base_cnt   = clr_i ? '0 : cnt_q;
    inc        = {1'b0, aw_hs_i} + {1'b0, ar_hs_i};
    sum        = {1'b0, base_cnt} + SumWidth'(inc);

    valid_d    = base_valid;
    addr_d     = clr_i ? '0 : addr_q;
    is_write_d = clr_i ? 1'b0 : is_write_q;
    if (!base_valid && (aw_hs_i || ar_hs_i)) begin
      valid_d    = 1'b1;
      // AW wins when both channels hand shake together.
      addr_d     = aw_hs_i ? aw_addr_i : ar_addr_i;
      is_write_d = aw_hs_i;
    end

    cnt_d = sum[CntWidth] ? {CntWidth{1'b1}} : sum[CntWidth-1:0];
  end

  // Capture and counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      is_write_q <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign err_addr_o     = addr_q;
  assign err_is_write_o = is_write_q;
  assign err_valid_o    = valid_q;
  assign err_cnt_o      = cnt_q;

endmodule

// File: rtl/soc_decerr_responder.sv
// AXI4 default slave: drains writes, answers every burst with DECERR and
// records the first offending address for software.
module soc_decerr_responder
  import soc_decerr_responder_pkg::*;
#(
  parameter int unsigned          IdWidth   = IdWidthSlave,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] ErrData   = DataWidth'(DecErrData),
  parameter int unsigned          CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  input  logic                 err_clr_i,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_is_write_o,
  output logic                 err_valid_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic                 irq_o
);

  w_state_e           w_state_q, w_state_d;
  r_state_e           r_state_q, r_state_d;
  logic [IdWidth-1:0] b_id_q, b_id_d;
  logic [IdWidth-1:0] r_id_q, r_id_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_q, beat_d;

  logic aw_hs, ar_hs;

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;

  // Write channel: accept AW, swallow W beats up to last, then return B.
  always_comb begin
    w_state_d  = w_state_q;
    b_id_d     = b_id_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          b_id_d    = aw_id_i;
          w_state_d = WDrain;
        end
      end
      WDrain: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) begin
          w_state_d = WResp;
        end
      end
      WResp: begin
        b_valid_o = 1'b1;
        if (b_ready_i) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read channel: accept AR, stream len+1 error beats.
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    len_d      = len_q;
    beat_d     = beat_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          r_id_d    = ar_id_i;
          len_d     = ar_len_i;
          beat_d    = '0;
          r_state_d = RData;
        end
      end
      RData: begin
        r_valid_o = 1'b1;
        r_last_o  = (beat_q == len_q);
        if (r_ready_i) begin
          beat_d = beat_q + 8'd1;
          if (r_last_o) begin
            r_state_d = RIdle;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Channel state and latched transaction attributes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      b_id_q    <= '0;
      r_id_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      b_id_q    <= b_id_d;
      r_id_q    <= r_id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
    end
  end

  assign b_id_o   = b_id_q;
  assign b_resp_o = AxiRespDecErr;
  assign r_id_o   = r_id_q;
  assign r_resp_o = AxiRespDecErr;
  assign r_data_o = ErrData;

  soc_decerr_capture #(
    .AddrWidth (AddrWidth),
    .CntWidth  (CntWidth)
  ) u_capture (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clr_i          (err_clr_i),
    .aw_hs_i        (aw_hs),
    .aw_addr_i      (aw_addr_i),
    .ar_hs_i        (ar_hs),
    .ar_addr_i      (ar_addr_i),
    .err_addr_o     (err_addr_o),
    .err_is_write_o (err_is_write_o),
    .err_valid_o    (err_valid_o),
    .err_cnt_o      (err_cnt_o)
  );

  assign irq_o = err_valid_o;

endmodule
